// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the seven-segment scan capture block
package seg_scan_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETTLE  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_HOLD    = 2'd3;

  // Bus geometry and bit positions
  localparam int NUM_DIGITS  = 4;
  localparam int ANODE_W     = 4;
  localparam int SEG_W       = 8;
  localparam int SEG_A_BIT   = 0;
  localparam int SEG_G_BIT   = 6;
  localparam int SEG_DP_BIT  = 7;
  localparam int NIBBLE_W    = 4;

  // Active-low hex segment patterns with dp off
  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  function automatic logic [6:0] seg_hex_segs(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = SEG_HEX_0;
      4'h1: p = SEG_HEX_1;
      4'h2: p = SEG_HEX_2;
      4'h3: p = SEG_HEX_3;
      4'h4: p = SEG_HEX_4;
      4'h5: p = SEG_HEX_5;
      4'h6: p = SEG_HEX_6;
      4'h7: p = SEG_HEX_7;
      4'h8: p = SEG_HEX_8;
      4'h9: p = SEG_HEX_9;
      4'hA: p = SEG_HEX_A;
      4'hB: p = SEG_HEX_B;
      4'hC: p = SEG_HEX_C;
      4'hD: p = SEG_HEX_D;
      4'hE: p = SEG_HEX_E;
      default: p = SEG_HEX_F;
    endcase
    return p[SEG_G_BIT:SEG_A_BIT];
  endfunction

  // Returns {valid, index} for an active-low one-hot anode select
  function automatic logic [2:0] anode_onehot_low(input logic [ANODE_W-1:0] an);
    case (an)
      4'b1110: return {1'b1, 2'd0};
      4'b1101: return {1'b1, 2'd1};
      4'b1011: return {1'b1, 2'd2};
      4'b0111: return {1'b1, 2'd3};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low segment pattern to hex nibble lookup
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  // Unknown patterns decode to nibble 0 with the error flag raised
  always_comb begin
    o_nibble = '0;
    o_err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == seg_hex_segs(4'(i))) begin
        o_nibble = 4'(i);
        o_err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - recovers 4-digit frames from a multiplexed seven-segment display scan
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  display_data,
  input  logic [7:0]  dispcode,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        overrun,
  output logic        scan_lost
);

  localparam int                TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]        SETTLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [ANODE_W-1:0] r_anode;
  logic [SEG_W-1:0]   r_code;
  state_t             r_state;
  logic [ANODE_W-1:0] r_sel_anode;
  logic [1:0]         r_sel_idx;
  logic [7:0]         r_settle;
  logic [3:0]         r_seen;
  logic [15:0]        r_work_digits;
  logic [3:0]         r_work_dp;
  logic [3:0]         r_work_err;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_frame_valid;
  logic [15:0]        r_digits;
  logic [3:0]         r_dp;
  logic [3:0]         r_err;
  logic               r_overrun;

  logic [2:0] w_anode_dec;
  logic [3:0] w_dec_nibble;
  logic       w_dec_err;
  logic       w_capture;
  logic       w_complete;
  logic       w_lost;

  assign w_anode_dec = anode_onehot_low(r_anode);
  assign w_capture   = (r_state == ST_CAPTURE);
  assign w_complete  = (r_seen == 4'hF);
  assign w_lost      = (r_tmo == TMO_MAX);

  seg7_decode u_decode (
    .i_seg    (r_code[SEG_G_BIT:SEG_A_BIT]),
    .o_nibble (w_dec_nibble),
    .o_err    (w_dec_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode       <= '0;
      r_code        <= '0;
      r_state       <= ST_IDLE;
      r_sel_anode   <= '0;
      r_sel_idx     <= '0;
      r_settle      <= '0;
      r_seen        <= '0;
      r_work_digits <= '0;
      r_work_dp     <= '0;
      r_work_err    <= '0;
      r_tmo         <= '0;
      r_frame_valid <= 1'b0;
      r_digits      <= '0;
      r_dp          <= '0;
      r_err         <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_anode <= display_data;
      r_code  <= dispcode;

      // The IDLE cycle that first sees the anode counts as its first stable cycle
      case (r_state)
        ST_IDLE: begin
          if (w_anode_dec[2]) begin
            r_sel_anode <= r_anode;
            r_sel_idx   <= w_anode_dec[1:0];
            r_settle    <= 8'd1;
            r_state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_anode != r_sel_anode) begin
            r_state <= ST_IDLE;
          end else if (r_settle >= SETTLE_LAST) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_settle <= r_settle + 8'd1;
          end
        end
        ST_CAPTURE: begin
          r_work_digits[{r_sel_idx, 2'b00} +: 4] <= w_dec_nibble;
          r_work_dp[r_sel_idx]  <= ~r_code[SEG_DP_BIT];
          r_work_err[r_sel_idx] <= w_dec_err;
          r_state               <= ST_HOLD;
        end
        default: begin
          if (r_anode != r_sel_anode) r_state <= ST_IDLE;
        end
      endcase

      // Seen mask and timeout: a capture wins over completion or loss clearing
      if (w_capture) begin
        r_seen <= r_seen | (4'b0001 << r_sel_idx);
        r_tmo  <= '0;
      end else begin
        if (w_complete || w_lost) r_seen <= '0;
        if (!w_lost) r_tmo <= r_tmo + 1'b1;
      end

      // Output frame handshake; a pending unaccepted frame is never overwritten
      if (w_complete) begin
        if (!r_frame_valid || frame_ready) begin
          r_digits      <= r_work_digits;
          r_dp          <= r_work_dp;
          r_err         <= r_work_err;
          r_frame_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign digits      = r_digits;
  assign dp          = r_dp;
  assign digit_err   = r_err;
  assign overrun     = r_overrun;
  assign scan_lost   = w_lost;

endmodule
